renode_axi_manager_arbiter: RTL and testbench
=============================================

// Module: renode_axi_manager_arbiter
// PURPOSE
// - Shares one AXI manager port between N single-beat requesters (Renode controllers, DMA stubs).
// - Round-robin grant; one outstanding transaction at a time; every burst is single-beat (len=0).
// - Response is returned to the granted requester as a one-cycle pulse.
// PARAMETERS
// - Requesters       4   number of requester ports, 1..16
// - AddressWidth    32   AXI address width
// - DataWidth       32   AXI data width, power of 2, >=8
// - IdWidth          4   AXI ID width, >= $clog2(Requesters)
// PORTS
// - aclk          in   1             clock, all logic on posedge
// - areset        in   1             synchronous, active-high reset
// - req_valid     in   N             request pending; held high until matching resp_valid
// - req_write     in   N             1=write, 0=read
// - req_addr      in   N*AW          byte address, aligned to req_size
// - req_size      in   N*3           burst_size_t (log2 bytes)
// - req_wdata     in   N*DW          write data, lane-positioned
// - req_wstrb     in   N*DW/8        write strobes
// - resp_valid    out  N             one-cycle completion pulse to the granted requester
// - resp_rdata    out  DW            read data, valid with resp_valid
// - resp_error    out  1             SLVERR/DECERR, or ID mismatch, valid with resp_valid
// - aw*/w*/b*/ar*/r*  AXI manager channels: awid/addr/size/len/burst/valid/ready, wdata/strb/last/valid/ready,
//                 bid/resp/valid/ready, arid/addr/size/len/burst/valid/ready, rid/data/resp/last/valid/ready
// BEHAVIOUR
// - Reset: all *valid, *ready, resp_valid = 0; resp_rdata = 0; resp_error = 0; state=IDLE; rr pointer=0.
// - Reset mid-transaction: abandons it and returns to IDLE without issuing resp_valid.
// - Constant fields: len=0, burst=INCR(1), lock=0, prot=0, wlast=1; id = granted index.
// - FSM: IDLE -> (write ? WR_REQ : RD_REQ) -> (WR_RESP | RD_RESP) -> DONE -> IDLE.
// - IDLE: with any req_valid, pick grant; latch addr/size/data/strb/write into registers; next state.
// - RD_REQ: arvalid=1 and rready=1. arvalid drops the cycle after arvalid&arready.
//   If rvalid arrives in the same cycle as the AR handshake, go straight to DONE.
// - RD_RESP: rready=1; on rvalid, capture rdata, rresp and rid -> DONE.
// - WR_REQ: awvalid=1, wvalid=1, bready=1. Each valid drops independently after its own handshake.
//   AW and W may complete in either order or in the same cycle.
// - WR_RESP: entered when both AW and W are done; on bvalid, capture bresp and bid -> DONE.
// - DONE: resp_valid[grant]=1 for exactly 1 cycle; resp_rdata is 0 for writes.
//   resp_error = (resp>=2) || (id!=grant); EXOKAY counts as success.
// - Minimum latency with ready=1 and same-cycle response: req_valid to resp_valid is 3 cycles.
// - No new grant in DONE; the requester drops req_valid on the cycle after resp_valid.
// - Round-robin: search starts at last_grant+1 and wraps N-1 -> 0. The pointer updates on grant only.
// - Requests that go away before being granted are ignored; the granted request is fully latched.
// CONFIGURATION
// - RENODE_AXI_ARB_FIXED_PRIO_EN defined: requester 0 always wins, then 1, and so on.
//   The round-robin pointer is not built.
// - Macro undefined: round-robin as above.
// STRUCTURE
// - renode_axi_pkg additions: arb_state_e {Idle, RdReq, RdResp, WrReq, WrResp, Done}.
//   Reuse burst_size_t and response_e.
// - Sub-module renode_axi_rr_arbiter (req vector, advance strobe -> one-hot grant + index).
//   The fixed-priority option lives inside it.
// TESTING
// - Single read, req 0 addr 0x10 size 2, subordinate returns 0xDEADBEEF OKAY
//   -> araddr=0x10, arsize=2, arid=0; resp_valid[0]=1 for one cycle; rdata=0xDEADBEEF; error=0.
// - Write addr 0x4, wdata 0x00AB0000, wstrb 0100; awready 3 cycles after wready
//   -> wvalid dropped first; one B; resp_valid pulse; error=0.
// - All 4 requesters held high, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
//   With FIXED_PRIO_EN -> 0 repeatedly while req 0 is held.
// - Read returns rresp=SLVERR; separately, a write returns bid=3 while grant=1 -> resp_error=1 in both.
// - areset pulsed while in WR_RESP -> all valids 0 next cycle, no resp_valid.
//   The next request then completes normally.

Source files
------------

// File: rtl/renode_axi_pkg.sv
// Shared types for the Renode AXI manager arbiter.
// Burst sizes, AXI responses and arbiter FSM states.
package renode_axi_pkg;

  typedef enum logic [2:0] {
    Size1   = 3'd0,
    Size2   = 3'd1,
    Size4   = 3'd2,
    Size8   = 3'd3,
    Size16  = 3'd4,
    Size32  = 3'd5,
    Size64  = 3'd6,
    Size128 = 3'd7
  } burst_size_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } response_e;

  typedef enum logic [2:0] {
    Idle,
    RdReq,
    RdResp,
    WrReq,
    WrResp,
    Done
  } arb_state_e;

  localparam logic [1:0] BurstIncr = 2'b01;

  // SLVERR and DECERR fail; OKAY and EXOKAY succeed
  function automatic logic resp_is_err(response_e r);
    return r[1];
  endfunction

endpackage

// File: rtl/renode_axi_manager_arbiter_if.sv
// AXI manager-side channel bundle for the Renode arbiter.
// master = manager driving AW/W/AR, slave = subordinate.
interface renode_axi_manager_arbiter_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int IdWidth      = 4
) ();
  import renode_axi_pkg::*;

  logic [IdWidth-1:0]     awid;
  logic [AddressWidth-1:0] awaddr;
  burst_size_t            awsize;
  logic [7:0]             awlen;
  logic [1:0]             awburst;
  logic                   awlock;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;

  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [IdWidth-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [IdWidth-1:0]     arid;
  logic [AddressWidth-1:0] araddr;
  burst_size_t            arsize;
  logic [7:0]             arlen;
  logic [1:0]             arburst;
  logic                   arlock;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;

  logic [IdWidth-1:0]     rid;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awid, awaddr, awsize, awlen, awburst,
    output awlock, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arsize, arlen, arburst,
    output arlock, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awsize, awlen, awburst,
    input  awlock, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arsize, arlen, arburst,
    input  arlock, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/renode_axi_rr_arbiter.sv
// Round-robin requester picker; RENODE_AXI_ARB_FIXED_PRIO_EN
// swaps it for fixed priority (index 0 highest, no pointer).
module renode_axi_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] start;
  logic [IW-1:0] idx;
  logic          hit;

`ifdef RENODE_AXI_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = clk_i ^ rst_i ^ advance_i;
  assign start     = '0;
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // search resumes just after the last winner
  assign ptr_d = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && hit) begin
      ptr_q <= ptr_d;
    end
  end

  assign start = ptr_q;
`endif

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit && req_i[(int'(start) + i) % N]) begin
        hit = 1'b1;
        idx = IW'((int'(start) + i) % N);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (hit) gnt_o[idx] = 1'b1;
  end

  assign idx_o   = idx;
  assign valid_o = hit;

endmodule

// File: rtl/renode_axi_manager_arbiter.sv
// Shares one AXI manager port among N single-beat requesters.
// Build option: RENODE_AXI_ARB_FIXED_PRIO_EN (fixed priority grant).
module renode_axi_manager_arbiter
  import renode_axi_pkg::*;
#(
  parameter int Requesters   = 4,
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int IdWidth      = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic [Requesters-1:0]              req_valid,
  input  logic [Requesters-1:0]              req_write,
  input  logic [Requesters*AddressWidth-1:0] req_addr,
  input  logic [Requesters*3-1:0]            req_size,
  input  logic [Requesters*DataWidth-1:0]    req_wdata,
  input  logic [Requesters*DataWidth/8-1:0]  req_wstrb,
  output logic [Requesters-1:0]              resp_valid,
  output logic [DataWidth-1:0]               resp_rdata,
  output logic                               resp_error,
  renode_axi_manager_arbiter_if.master       axi
);

  localparam int SW = DataWidth / 8;
  localparam int GW = (Requesters > 1) ? $clog2(Requesters) : 1;

  arb_state_e state_q;
  logic [GW-1:0]           gidx_q;
  logic [Requesters-1:0]   goh_q;
  logic                    write_q;
  logic [AddressWidth-1:0] addr_q;
  burst_size_t             size_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [SW-1:0]           wstrb_q;
  logic awvalid_q, wvalid_q, bready_q;
  logic arvalid_q, rready_q;
  logic [DataWidth-1:0]    rdata_q;
  response_e               rsp_q;
  logic [IdWidth-1:0]      rid_q;
  logic [Requesters-1:0]   resp_valid_q;
  logic [DataWidth-1:0]    resp_rdata_q;
  logic                    resp_error_q;

  logic [Requesters-1:0] gnt_oh;
  logic [GW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic                  grant_go;
  logic                  aw_ok;
  logic                  w_ok;
  logic                  unused_ok;

  // hold off while the pulse is out so the finishing requester can drop
  assign grant_go = (state_q == Idle) && gnt_vld && !(|resp_valid_q);
  assign aw_ok    = !awvalid_q || axi.awready;
  assign w_ok     = !wvalid_q || axi.wready;

  renode_axi_rr_arbiter #(.N(Requesters)) u_arb (
    .clk_i     (aclk),
    .rst_i     (areset),
    .req_i     (req_valid),
    .advance_i (grant_go),
    .gnt_o     (gnt_oh),
    .idx_o     (gnt_idx),
    .valid_o   (gnt_vld)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= Idle;
      gidx_q       <= '0;
      goh_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= Size1;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rdata_q      <= '0;
      rsp_q        <= RespOkay;
      rid_q        <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      unique case (state_q)
        Idle: begin
          if (grant_go) begin
            gidx_q  <= gnt_idx;
            goh_q   <= gnt_oh;
            write_q <= req_write[gnt_idx];
            addr_q  <= req_addr[gnt_idx*AddressWidth +: AddressWidth];
            size_q  <= burst_size_t'(req_size[gnt_idx*3 +: 3]);
            wdata_q <= req_wdata[gnt_idx*DataWidth +: DataWidth];
            wstrb_q <= req_wstrb[gnt_idx*SW +: SW];
            if (req_write[gnt_idx]) begin
              state_q   <= WrReq;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
            end else begin
              state_q   <= RdReq;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        RdReq: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            if (axi.rvalid) begin
              rdata_q  <= axi.rdata;
              rsp_q    <= response_e'(axi.rresp);
              rid_q    <= axi.rid;
              rready_q <= 1'b0;
              state_q  <= Done;
            end else begin
              state_q <= RdResp;
            end
          end
        end
        RdResp: begin
          if (axi.rvalid) begin
            rdata_q  <= axi.rdata;
            rsp_q    <= response_e'(axi.rresp);
            rid_q    <= axi.rid;
            rready_q <= 1'b0;
            state_q  <= Done;
          end
        end
        WrReq: begin
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) state_q <= WrResp;
        end
        WrResp: begin
          if (axi.bvalid) begin
            rsp_q    <= response_e'(axi.bresp);
            rid_q    <= axi.bid;
            bready_q <= 1'b0;
            state_q  <= Done;
          end
        end
        Done: begin
          resp_valid_q <= goh_q;
          resp_rdata_q <= write_q ? '0 : rdata_q;
          resp_error_q <= resp_is_err(rsp_q) ||
                          (rid_q != IdWidth'(gidx_q));
          state_q      <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign axi.awid    = IdWidth'(gidx_q);
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = size_q;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = BurstIncr;
  assign axi.awlock  = 1'b0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arid    = IdWidth'(gidx_q);
  assign axi.araddr  = addr_q;
  assign axi.arsize  = size_q;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = BurstIncr;
  assign axi.arlock  = 1'b0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_error  = resp_error_q;

  // every beat is the last one, so rlast carries no information
  assign unused_ok   = axi.rlast;

endmodule

// File: tb/tb_renode_axi_manager_arbiter.sv
// Directed bench for renode_axi_manager_arbiter: vector table
// plus round-robin and mid-transaction reset sequences.
module tb_renode_axi_manager_arbiter;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [11:0]  req_size;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_error;

  int n_tests = 0;
  int n_fail  = 0;

  renode_axi_manager_arbiter_if #(
    .AddressWidth(32), .DataWidth(32), .IdWidth(4)
  ) axi ();

  renode_axi_manager_arbiter #(
    .Requesters(4), .AddressWidth(32),
    .DataWidth(32), .IdWidth(4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .axi        (axi)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          id_ovr;
    int          adly;
    int          wdly;
    int          rdly;
    bit          exp_err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sub_idle();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b1;
  endtask

  task automatic set_req(input int i, input vec_t v);
    req_write[i]          = v.wr;
    req_addr[i*32 +: 32]  = v.addr;
    req_size[i*3 +: 3]    = v.size;
    req_wdata[i*32 +: 32] = v.wdata;
    req_wstrb[i*4 +: 4]   = v.wstrb;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int  ar_at = -1;
    int  aw_at = -1;
    int  w_at  = -1;
    bit  seen  = 0;
    bit  sent  = 0;
    bit  done  = 0;
    bit  aw_hs, w_hs;
    int  last;
    set_req(v.idx, v);
    req_valid[v.idx] = 1'b1;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge aclk);
      if (resp_valid != 0) begin
        check({tag, ".resp_valid"}, 64'(resp_valid), 64'(1 << v.idx));
        check({tag, ".rdata"}, 64'(resp_rdata),
              64'(v.wr ? 32'h0 : v.rdata));
        check({tag, ".error"}, 64'(resp_error), 64'(v.exp_err));
        if (v.lat > 0) check({tag, ".latency"}, 64'(k), 64'(v.lat));
        req_valid[v.idx] = 1'b0;
        done = 1;
      end else if (!v.wr) begin
        axi.arready = axi.arvalid && (k >= v.adly);
        if (axi.arvalid && !seen) begin
          seen = 1;
          check({tag, ".ar_fields"},
                64'({axi.araddr, axi.arsize, axi.arid, axi.arlen,
                     axi.arburst, axi.arlock, axi.arprot}),
                64'({v.addr, v.size, 4'(v.idx), 8'd0, 2'b01,
                     1'b0, 3'd0}));
        end
        if (axi.arvalid && axi.arready) ar_at = k;
        axi.rvalid = (ar_at >= 0) && !sent && (k >= ar_at + v.rdly);
        axi.rdata  = v.rdata;
        axi.rresp  = v.resp;
        axi.rid    = (v.id_ovr < 0) ? axi.arid : 4'(v.id_ovr);
        if (axi.rvalid && axi.rready) sent = 1;
      end else begin
        axi.awready = axi.awvalid && (k >= v.adly);
        axi.wready  = axi.wvalid && (k >= v.wdly);
        if (axi.awvalid && !seen) begin
          seen = 1;
          check({tag, ".aw_fields"},
                64'({axi.awaddr, axi.awsize, axi.awid, axi.awlen,
                     axi.awburst, axi.awlock, axi.awprot}),
                64'({v.addr, v.size, 4'(v.idx), 8'd0, 2'b01,
                     1'b0, 3'd0}));
          check({tag, ".w_fields"},
                64'({axi.wdata, axi.wstrb, axi.wlast, axi.wvalid}),
                64'({v.wdata, v.wstrb, 1'b1, 1'b1}));
        end
        aw_hs = axi.awvalid && axi.awready;
        w_hs  = axi.wvalid && axi.wready;
        if (aw_hs) check({tag, ".wvalid_at_aw"},
                         64'(axi.wvalid), 64'(w_at < 0));
        if (w_hs) check({tag, ".awvalid_at_w"},
                        64'(axi.awvalid), 64'(aw_at < 0));
        if (aw_hs) aw_at = k;
        if (w_hs)  w_at  = k;
        last = (aw_at > w_at) ? aw_at : w_at;
        axi.bvalid = (aw_at >= 0) && (w_at >= 0) && !sent &&
                     (k >= last + 1 + v.rdly);
        axi.bresp  = v.resp;
        axi.bid    = (v.id_ovr < 0) ? axi.awid : 4'(v.id_ovr);
        if (axi.bvalid && axi.bready) sent = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: no resp_valid within 40 cycles", tag);
      req_valid[v.idx] = 1'b0;
    end
    sub_idle();
    @(negedge aclk);
    check({tag, ".pulse_end"}, 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int   exp_g;
    bit   got;
    logic [3:0] dropped;
    logic seen_resp;

    // idx wr addr size wdata wstrb rdata resp id_ovr adly wdly rdly err lat
    vecs[0] = '{0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0,
                32'hDEADBEEF, 2'd0, -1, 1, 1, 0, 1'b0, 3};
    vecs[1] = '{0, 1'b1, 32'h4, 3'd2, 32'h00AB0000, 4'b0100,
                32'h0, 2'd0, -1, 4, 1, 0, 1'b0, 7};
    vecs[2] = '{2, 1'b0, 32'h20, 3'd2, 32'h0, 4'h0,
                32'h12345678, 2'd2, -1, 2, 1, 2, 1'b1, 6};
    vecs[3] = '{1, 1'b1, 32'h8, 3'd2, 32'h11223344, 4'hF,
                32'h0, 2'd0, 3, 1, 1, 1, 1'b1, 5};
    vecs[4] = '{3, 1'b0, 32'h2, 3'd1, 32'h0, 4'h0,
                32'hCAFEF00D, 2'd1, -1, 1, 1, 0, 1'b0, 3};
    vecs[5] = '{2, 1'b1, 32'h30, 3'd2, 32'hA5A5A5A5, 4'hF,
                32'h0, 2'd3, -1, 3, 3, 0, 1'b1, 6};
    vecs[6] = '{1, 1'b0, 32'h44, 3'd2, 32'h0, 4'h0,
                32'h0BADF00D, 2'd0, -1, 1, 1, 3, 1'b0, 6};
    vecs[7] = '{3, 1'b1, 32'hFC, 3'd2, 32'h000000EE, 4'b0001,
                32'h0, 2'd1, -1, 1, 2, 0, 1'b0, 5};

    areset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    sub_idle();
    repeat (3) @(negedge aclk);
    check("reset.valids",
          64'({axi.awvalid, axi.wvalid, axi.bready,
               axi.arvalid, axi.rready, resp_valid}), 64'(0));
    check("reset.resp", 64'({resp_rdata, resp_error}), 64'(0));
    areset = 1'b0;

    // four readers held high; each drops for one cycle after its pulse
    for (int i = 0; i < 4; i++) begin
      req_write[i]         = 1'b0;
      req_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
      req_size[i*3 +: 3]   = 3'd2;
    end
    req_valid = 4'hF;
    for (int n = 0; n < 8; n++) begin
`ifdef RENODE_AXI_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = n % 4;
`endif
      got     = 0;
      dropped = '0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge aclk);
        if (resp_valid != 0) begin
          check("rr.resp_valid", 64'(resp_valid), 64'(1 << exp_g));
          dropped   = resp_valid;
          req_valid = req_valid & ~resp_valid;
          got       = 1;
        end else if (axi.arvalid) begin
          check("rr.arid", 64'(axi.arid), 64'(exp_g));
        end
        axi.arready = axi.arvalid;
        axi.rvalid  = axi.arvalid;
        axi.rid     = axi.arid;
        axi.rdata   = 32'h5A5A0000 + 32'(n);
        axi.rresp   = 2'd0;
      end
      if (!got) begin
        n_tests++;
        n_fail++;
        $display("FAIL rr.timeout: txn %0d never completed", n);
      end
      sub_idle();
      @(negedge aclk);
      req_valid = req_valid | dropped;
    end
    req_valid = '0;
    repeat (3) @(negedge aclk);

    foreach (vecs[i]) do_txn(vecs[i], $sformatf("vec%0d", i));

    // reset while waiting for B
    set_req(1, vecs[3]);
    req_valid[1] = 1'b1;
    @(negedge aclk);
    axi.awready = axi.awvalid;
    axi.wready  = axi.wvalid;
    @(negedge aclk);
    sub_idle();
    check("rst.in_wr_resp",
          64'({axi.awvalid, axi.wvalid, axi.bready}), 64'(3'b001));
    areset    = 1'b1;
    req_valid = '0;
    @(negedge aclk);
    check("rst.valids",
          64'({axi.awvalid, axi.wvalid, axi.bready,
               axi.arvalid, axi.rready, resp_valid}), 64'(0));
    areset    = 1'b0;
    seen_resp = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      seen_resp = seen_resp | (|resp_valid);
    end
    check("rst.no_resp", 64'(seen_resp), 64'(0));
    do_txn(vecs[6], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
